// File: rtl/enigma_pkg.sv
// enigma_pkg: shared types and constants for the Enigma character sequencer.
// Holds the FSM state enum, ASCII anchors, the letter-index type and
// helpers for validating rotor start positions.
package enigma_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SEND = 3'd2,
    WAIT = 3'd3,
    EMIT = 3'd4
  } state_t;

  // Letter index 0..25 ('A'..'Z')
  typedef logic [4:0] letter_idx_t;

  localparam logic [7:0] ASCII_A       = 8'h41;
  localparam logic [7:0] ASCII_Z       = 8'h5A;
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;
  localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;
  localparam int         NUM_LETTERS   = 26;

  // True when a rotor position names a real letter
  function automatic logic pos_in_range(input letter_idx_t p);
    return (int'(p) < NUM_LETTERS);
  endfunction

  // Out-of-range rotor positions collapse to 'A' (0)
  function automatic letter_idx_t sanitize_pos(input letter_idx_t p);
    letter_idx_t r;
    if (pos_in_range(p)) begin
      r = p;
    end else begin
      r = 5'd0;
    end
    return r;
  endfunction

endpackage

// File: rtl/enigma_seq_ascii_letter_map.sv
// ascii_letter_map: combinational classifier from an ASCII byte to
// {is_letter, letter index}. Lowercase folds onto the same index as its
// uppercase counterpart so the core only ever sees 0..25.
module ascii_letter_map
  import enigma_pkg::*;
(
  input  logic [7:0]  i_byte,
  output logic        o_is_letter,
  output letter_idx_t o_index
);

  logic w_is_upper;
  logic w_is_lower;

  assign w_is_upper = (i_byte >= ASCII_A) && (i_byte <= ASCII_Z);
  assign w_is_lower = (i_byte >= ASCII_LOWER_A) && (i_byte <= ASCII_LOWER_Z);

  // Classify the byte and derive its case-folded letter index
  always_comb begin
    o_is_letter = 1'b0;
    o_index     = 5'd0;
    if (w_is_upper) begin
      o_is_letter = 1'b1;
      o_index     = letter_idx_t'(i_byte - ASCII_A);
    end else if (w_is_lower) begin
      o_is_letter = 1'b1;
      o_index     = letter_idx_t'(i_byte - ASCII_LOWER_A);
    end else begin
      o_is_letter = 1'b0;
      o_index     = 5'd0;
    end
  end

endmodule

// File: rtl/enigma_seq.sv
// enigma_seq: byte-stream sequencer in front of an Enigma rotor core.
// Accepts ASCII bytes, steps the core once per letter, returns the
// enciphered letter as uppercase ASCII, and loads rotor start positions.
// Optional feature macro: ENIGMA_PASSTHRU_EN -- when defined, non-letter
// bytes are forwarded unchanged; otherwise they are accepted and dropped.
module enigma_seq
  import enigma_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  input  logic        cfg_valid,
  input  logic [4:0]  cfg_pos1,
  input  logic [4:0]  cfg_pos2,
  input  logic [4:0]  cfg_pos3,
  output logic        cfg_err,
  output logic [4:0]  core_char,
  output logic        core_valid,
  output logic        core_load,
  output logic [4:0]  core_pos1,
  output logic [4:0]  core_pos2,
  output logic [4:0]  core_pos3,
  input  logic [4:0]  core_char_out,
  input  logic        core_valid_out,
  output logic [15:0] char_cnt
);

  state_t      r_state;
  state_t      w_next_state;

  logic [7:0]  r_m_data;
  logic        r_m_valid;
  logic [4:0]  r_core_char;
  logic        r_core_valid;
  logic        r_core_load;
  logic [4:0]  r_core_pos1;
  logic [4:0]  r_core_pos2;
  logic [4:0]  r_core_pos3;
  logic        r_cfg_err;
  logic [15:0] r_char_cnt;
  logic        r_is_letter;

  logic        w_is_letter;
  letter_idx_t w_index;
  logic        w_s_ready;
  logic        w_accept;
  logic        w_load_go;
  logic        w_cfg_bad;
  logic        w_emit_done;

  ascii_letter_map u_map (
    .i_byte      (s_data),
    .o_is_letter (w_is_letter),
    .o_index     (w_index)
  );

  // Input is only taken in IDLE, and a pending load request wins over data
  assign w_s_ready   = rst && (r_state == IDLE) && !cfg_valid;
  assign w_accept    = w_s_ready && s_valid;
  assign w_load_go   = (w_next_state == LOAD);
  assign w_emit_done = (r_state == EMIT) && m_ready;
  assign w_cfg_bad   = !pos_in_range(cfg_pos1) || !pos_in_range(cfg_pos2) ||
                       !pos_in_range(cfg_pos3);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decision
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (cfg_valid) begin
          w_next_state = LOAD;
        end else if (s_valid) begin
          if (w_is_letter) begin
            w_next_state = SEND;
          end else begin
`ifdef ENIGMA_PASSTHRU_EN
            w_next_state = EMIT;
`else
            w_next_state = IDLE;
`endif
          end
        end else begin
          w_next_state = IDLE;
        end
      end
      LOAD: w_next_state = IDLE;
      SEND: w_next_state = WAIT;
      WAIT: begin
        if (core_valid_out) begin
          w_next_state = EMIT;
        end else begin
          w_next_state = WAIT;
        end
      end
      EMIT: begin
        if (m_ready) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = EMIT;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Strobes are registered from the next state so each lasts exactly one state
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_core_valid <= 1'b0;
      r_core_load  <= 1'b0;
      r_m_valid    <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_core_valid <= (w_next_state == SEND);
      r_core_load  <= w_load_go;
      r_m_valid    <= (w_next_state == EMIT);
      r_cfg_err    <= w_load_go && w_cfg_bad;
    end
  end

  // Sanitised rotor positions captured when a load is launched
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_core_pos1 <= 5'd0;
      r_core_pos2 <= 5'd0;
      r_core_pos3 <= 5'd0;
    end else if (w_load_go) begin
      r_core_pos1 <= sanitize_pos(cfg_pos1);
      r_core_pos2 <= sanitize_pos(cfg_pos2);
      r_core_pos3 <= sanitize_pos(cfg_pos3);
    end else begin
      r_core_pos1 <= r_core_pos1;
      r_core_pos2 <= r_core_pos2;
      r_core_pos3 <= r_core_pos3;
    end
  end

  // Letter index and letter/non-letter tag for the byte in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_core_char <= 5'd0;
      r_is_letter <= 1'b0;
    end else if (w_accept) begin
      r_is_letter <= w_is_letter;
      if (w_is_letter) begin
        r_core_char <= w_index;
      end else begin
        r_core_char <= r_core_char;
      end
    end else begin
      r_core_char <= r_core_char;
      r_is_letter <= r_is_letter;
    end
  end

  // Output byte: core result as uppercase ASCII, or a forwarded non-letter
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_m_data <= 8'h00;
    end else if ((r_state == WAIT) && core_valid_out) begin
      r_m_data <= ASCII_A + {3'b000, core_char_out};
`ifdef ENIGMA_PASSTHRU_EN
    end else if (w_accept && !w_is_letter) begin
      r_m_data <= s_data;
`endif
    end else begin
      r_m_data <= r_m_data;
    end
  end

  // Enciphered-letter counter: cleared on load, saturates at all-ones
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_char_cnt <= 16'd0;
    end else if (w_load_go) begin
      r_char_cnt <= 16'd0;
    end else if (w_emit_done && r_is_letter && (r_char_cnt != 16'hFFFF)) begin
      r_char_cnt <= r_char_cnt + 16'd1;
    end else begin
      r_char_cnt <= r_char_cnt;
    end
  end

  assign s_ready    = w_s_ready;
  assign m_data     = r_m_data;
  assign m_valid    = r_m_valid;
  assign cfg_err    = r_cfg_err;
  assign core_char  = r_core_char;
  assign core_valid = r_core_valid;
  assign core_load  = r_core_load;
  assign core_pos1  = r_core_pos1;
  assign core_pos2  = r_core_pos2;
  assign core_pos3  = r_core_pos3;
  assign char_cnt   = r_char_cnt;

endmodule

// File: tb/tb_enigma_seq.sv
// tb_enigma_seq: self-checking bench for enigma_seq with a stand-in rotor
// core (a position-offset reciprocal letter pairing, 'A'<->'U' at offset 0).
`timescale 1ns/1ps
module tb_enigma_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        cfg_valid;
  logic [4:0]  cfg_pos1, cfg_pos2, cfg_pos3;
  logic        cfg_err;
  logic [4:0]  core_char;
  logic        core_valid;
  logic        core_load;
  logic [4:0]  core_pos1, core_pos2, core_pos3;
  logic [4:0]  core_char_out;
  logic        core_valid_out;
  logic [15:0] char_cnt;

  always #5 clk = ~clk;

  enigma_seq dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .cfg_valid(cfg_valid), .cfg_pos1(cfg_pos1), .cfg_pos2(cfg_pos2), .cfg_pos3(cfg_pos3),
    .cfg_err(cfg_err),
    .core_char(core_char), .core_valid(core_valid), .core_load(core_load),
    .core_pos1(core_pos1), .core_pos2(core_pos2), .core_pos3(core_pos3),
    .core_char_out(core_char_out), .core_valid_out(core_valid_out),
    .char_cnt(char_cnt)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int perm[26];
  int model_k = 0;
  int exp_cnt = 0;
  bit passthru;

  int core_lat = 1;
  int core_cnt = 0;
  logic [4:0] core_pend = 5'd0;
  int core_k = 0;
  int core_valid_cnt = 0;
  int core_load_cnt = 0;
  int overlap_cnt = 0;

  typedef struct {
    logic [7:0] din;
    bit         letter;
    logic [7:0] dout;
  } vec_t;
  vec_t vecs[12];

  // Stand-in core: reciprocal pairing shifted by the sum of loaded positions
  function automatic int core_map(input int c, input int k);
    return (perm[(c + k) % 26] + 26 - k) % 26;
  endfunction

  function automatic bit ref_is_letter(input logic [7:0] b);
    return ((b >= 8'h41) && (b <= 8'h5A)) || ((b >= 8'h61) && (b <= 8'h7A));
  endfunction

  // Reference: uppercase letter from the folded index, non-letters unchanged
  function automatic logic [7:0] ref_out(input logic [7:0] b);
    int idx;
    if ((b >= 8'h61) && (b <= 8'h7A)) idx = int'(b) - 97;
    else idx = int'(b) - 65;
    if (ref_is_letter(b)) return 8'(65 + core_map(idx, model_k));
    else return b;
  endfunction

  // Core responder with adjustable latency, plus strobe monitors
  always @(posedge clk) begin
    core_valid_out <= 1'b0;
    if (core_load) begin
      core_k <= (int'(core_pos1) + int'(core_pos2) + int'(core_pos3)) % 26;
      core_load_cnt <= core_load_cnt + 1;
    end
    if (core_valid && core_load) overlap_cnt <= overlap_cnt + 1;
    if (core_valid) begin
      core_valid_cnt <= core_valid_cnt + 1;
      if (core_lat <= 1) begin
        core_valid_out <= 1'b1;
        core_char_out  <= 5'(core_map(int'(core_char), core_k));
        core_cnt       <= 0;
      end else begin
        core_cnt  <= core_lat - 1;
        core_pend <= core_char;
      end
    end else if (core_cnt == 1) begin
      core_valid_out <= 1'b1;
      core_char_out  <= 5'(core_map(int'(core_pend), core_k));
      core_cnt       <= 0;
    end else if (core_cnt > 1) begin
      core_cnt <= core_cnt - 1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst s_ready",   32'(s_ready), 32'd0);
    check("rst m_valid",   32'(m_valid), 32'd0);
    check("rst m_data",    32'(m_data), 32'd0);
    check("rst core_valid", 32'(core_valid), 32'd0);
    check("rst core_load", 32'(core_load), 32'd0);
    check("rst core_char", 32'(core_char), 32'd0);
    check("rst core_pos",  {17'd0, core_pos1, core_pos2, core_pos3}, 32'd0);
    check("rst cfg_err",   32'(cfg_err), 32'd0);
    check("rst char_cnt",  32'(char_cnt), 32'd0);
    rst = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic do_cfg(input logic [4:0] p1, input logic [4:0] p2, input logic [4:0] p3);
    logic [4:0] e1, e2, e3;
    bit eerr;
    e1 = (p1 > 5'd25) ? 5'd0 : p1;
    e2 = (p2 > 5'd25) ? 5'd0 : p2;
    e3 = (p3 > 5'd25) ? 5'd0 : p3;
    eerr = (p1 > 5'd25) || (p2 > 5'd25) || (p3 > 5'd25);
    @(negedge clk);
    cfg_pos1 = p1; cfg_pos2 = p2; cfg_pos3 = p3; cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("cfg core_load", 32'(core_load), 32'd1);
    check("cfg core_valid", 32'(core_valid), 32'd0);
    check("cfg core_pos", {17'd0, core_pos1, core_pos2, core_pos3}, {17'd0, e1, e2, e3});
    check("cfg cfg_err", 32'(cfg_err), 32'(eerr));
    check("cfg char_cnt", 32'(char_cnt), 32'd0);
    @(negedge clk);
    check("cfg load pulse", 32'(core_load), 32'd0);
    check("cfg err pulse", 32'(cfg_err), 32'd0);
    model_k = (int'(e1) + int'(e2) + int'(e3)) % 26;
    exp_cnt = 0;
  endtask

  // Offer one byte with m_ready high; lat counts cycles from accept to m_valid
  task automatic send_byte(input logic [7:0] b, input bit exp_out, input logic [7:0] exp_data,
                           input string nm, output int lat);
    int w;
    @(negedge clk);
    s_data = b; s_valid = 1'b1; w = 0;
    while (!s_ready && w < 50) begin @(negedge clk); w++; end
    check({nm, " s_ready"}, 32'(s_ready), 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
    lat = 1;
    while (!m_valid && lat < 12) begin @(negedge clk); lat++; end
    check({nm, " m_valid"}, 32'(m_valid), 32'(exp_out));
    if (exp_out && m_valid) begin
      check({nm, " m_data"}, 32'(m_data), 32'(exp_data));
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1);
  end

  initial begin
    int pa[13] = '{0, 1, 3, 5, 7, 9, 11, 13, 15, 17, 19, 22, 24};
    int pb[13] = '{20, 2, 4, 6, 8, 10, 12, 14, 16, 18, 21, 23, 25};
    int lat, vc0, lc0, hs, n;
    logic [7:0] b, d0, ex;
    bit mv;

`ifdef ENIGMA_PASSTHRU_EN
    passthru = 1'b1;
`else
    passthru = 1'b0;
`endif
    for (int i = 0; i < 13; i++) begin
      perm[pa[i]] = pb[i];
      perm[pb[i]] = pa[i];
    end

    vecs[0]  = '{8'h41, 1'b1, 8'h55};  // A -> U
    vecs[1]  = '{8'h75, 1'b1, 8'h41};  // u -> A
    vecs[2]  = '{8'h62, 1'b1, 8'h43};  // b -> C
    vecs[3]  = '{8'h5A, 1'b1, 8'h59};  // Z -> Y
    vecs[4]  = '{8'h7A, 1'b1, 8'h59};  // z -> Y
    vecs[5]  = '{8'h6E, 1'b1, 8'h4F};  // n -> O
    vecs[6]  = '{8'h54, 1'b1, 8'h56};  // T -> V
    vecs[7]  = '{8'h40, 1'b0, 8'h40};  // '@' just below 'A'
    vecs[8]  = '{8'h5B, 1'b0, 8'h5B};  // '[' just above 'Z'
    vecs[9]  = '{8'h60, 1'b0, 8'h60};  // '`' just below 'a'
    vecs[10] = '{8'h7B, 1'b0, 8'h7B};  // '{' just above 'z'
    vecs[11] = '{8'h20, 1'b0, 8'h20};  // space

    rst = 1'b0; s_data = 8'h00; s_valid = 1'b0; m_ready = 1'b1; cfg_valid = 1'b0;
    cfg_pos1 = 5'd0; cfg_pos2 = 5'd0; cfg_pos3 = 5'd0; core_char_out = 5'd0; core_valid_out = 1'b0;

    // Reset, zero positions, 'A' -> 'U' three cycles after accept
    do_reset();
    do_cfg(5'd0, 5'd0, 5'd0);
    send_byte(8'h41, 1'b1, 8'h55, "first A", lat);
    check("first A latency", 32'(lat), 32'd3);
    exp_cnt++;
    check("first A char_cnt", 32'(char_cnt), 32'(exp_cnt));

    // Table of letters, case folding and letter-range edges
    for (int i = 0; i < 12; i++) begin
      vc0 = core_valid_cnt;
      send_byte(vecs[i].din, vecs[i].letter || passthru,
                vecs[i].letter ? vecs[i].dout : vecs[i].din, $sformatf("vec%0d", i), lat);
      check($sformatf("vec%0d core_valid", i), 32'(core_valid_cnt - vc0), 32'(vecs[i].letter));
      if (vecs[i].letter) exp_cnt++;
    end
    check("table char_cnt", 32'(char_cnt), 32'(exp_cnt));

    // Out-of-range position is replaced, counter cleared
    do_cfg(5'd30, 5'd2, 5'd25);

    // Back-to-back throughput with s_valid and m_ready held high
    @(negedge clk);
    s_data = 8'h41; s_valid = 1'b1; hs = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_valid) hs++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    check("throughput handshakes", 32'(hs), 32'd10);
    exp_cnt += hs;
    check("throughput char_cnt", 32'(char_cnt), 32'(exp_cnt));

    // Random positions and random byte stream against the reference model
    do_cfg(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    for (int i = 0; i < 30; i++) begin
      n = $urandom_range(0, 9);
      if (n < 4) b = 8'(65 + $urandom_range(0, 25));
      else if (n < 8) b = 8'(97 + $urandom_range(0, 25));
      else b = 8'($urandom_range(32, 126));
      send_byte(b, ref_is_letter(b) || passthru, ref_out(b), $sformatf("rand%0d", i), lat);
      if (ref_is_letter(b)) exp_cnt++;
    end
    check("rand char_cnt", 32'(char_cnt), 32'(exp_cnt));

    // Back-pressure in EMIT and a load request raised while waiting on the core
    core_lat = 4; m_ready = 1'b0;
    @(negedge clk);
    s_data = 8'h43; s_valid = 1'b1;
    check("stall accept", 32'(s_ready), 32'd1);
    ex = ref_out(8'h43);
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    cfg_pos1 = 5'd3; cfg_pos2 = 5'd4; cfg_pos3 = 5'd5; cfg_valid = 1'b1;
    lc0 = core_load_cnt;
    n = 0;
    while (!m_valid && n < 20) begin @(negedge clk); n++; end
    check("stall m_valid", 32'(m_valid), 32'd1);
    check("stall m_data", 32'(m_data), 32'(ex));
    d0 = m_data; vc0 = core_valid_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall hold data", 32'(m_data), 32'(d0));
      check("stall hold valid", 32'(m_valid), 32'd1);
      check("stall s_ready", 32'(s_ready), 32'd0);
    end
    check("stall no core_valid", 32'(core_valid_cnt - vc0), 32'd0);
    check("stall no core_load", 32'(core_load_cnt - lc0), 32'd0);
    m_ready = 1'b1;
    @(negedge clk);
    check("deferred load not yet", 32'(core_load), 32'd0);
    check("stall char_cnt", 32'(char_cnt), 32'(exp_cnt + 1));
    @(negedge clk);
    cfg_valid = 1'b0;
    check("deferred load", 32'(core_load), 32'd1);
    check("deferred pos", {17'd0, core_pos1, core_pos2, core_pos3}, {17'd0, 5'd3, 5'd4, 5'd5});
    check("deferred char_cnt", 32'(char_cnt), 32'd0);
    model_k = 12; exp_cnt = 0; core_lat = 1;
    send_byte(8'h6B, 1'b1, ref_out(8'h6B), "after load", lat);
    exp_cnt++;

    // Reset while waiting on the core; the late core result must be ignored
    core_lat = 3;
    @(negedge clk);
    s_data = 8'h44; s_valid = 1'b1;
    check("wrst accept", 32'(s_ready), 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("wrst s_ready", 32'(s_ready), 32'd0);
    check("wrst m_valid", 32'(m_valid), 32'd0);
    check("wrst char_cnt", 32'(char_cnt), 32'd0);
    check("wrst core_valid", 32'(core_valid), 32'd0);
    rst = 1'b1;
    mv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (m_valid) mv = 1'b1;
    end
    check("wrst late result ignored", 32'(mv), 32'd0);
    check("wrst char_cnt after", 32'(char_cnt), 32'd0);
    core_lat = 1; exp_cnt = 0;

    // Recovery after reset
    do_cfg(5'd0, 5'd0, 5'd0);
    send_byte(8'h61, 1'b1, 8'h55, "recover a", lat);
    check("recover char_cnt", 32'(char_cnt), 32'd1);

    check("core_valid/core_load overlap", 32'(overlap_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/enigma_seq.md
ENIGMA_SEQ -- requirements
Module: enigma_seq

Interface
- REQ-001 The block SHALL have these ports, one per line as name, direction, width, meaning; reset is synchronous and active-low:
  clk  in  1  single clock
  rst  in  1  reset, synchronous, active-low
  s_data  in  8  input ASCII byte
  s_valid  in  1  input byte valid
  s_ready  out  1  input byte accepted when s_valid&s_ready
  m_data  out  8  output ASCII byte
  m_valid  out  1  output byte valid
  m_ready  in  1  downstream accepts m_data
  cfg_valid  in  1  load-rotor-positions request, pulse or level
  cfg_pos1/2/3  in  5 each  start positions, 0..25
  cfg_err  out  1  one-cycle pulse: a cfg_pos value was >25
  core_char  out  5  letter index 0..25 to core
  core_valid  out  1  core step strobe
  core_load  out  1  core position-load strobe
  core_pos1/2/3  out  5 each  sanitised start positions to core
  core_char_out  in  5  core result
  core_valid_out  in  1  core result valid, one cycle after core_valid
  char_cnt  out  16  letters enciphered since last reset/config

Function
- REQ-002 FSM states SHALL be IDLE, LOAD, SEND, WAIT, EMIT.
- REQ-003 IDLE: cfg_valid high -> LOAD (priority over s_valid); else s_valid high -> accept byte, go SEND if letter, EMIT if non-letter; s_ready=1 only in IDLE with cfg_valid low.
- REQ-004 Letter = 'A'..'Z' (0x41-0x5A) or 'a'..'z' (0x61-0x7A); lowercase folds to uppercase; index = byte-0x41 after folding.
- REQ-005 LOAD: core_load=1 for exactly one cycle, core_pos* = cfg_pos* with any value >25 replaced by 0, cfg_err pulses that cycle if any replaced, char_cnt cleared; next state IDLE.
- REQ-006 SEND: core_valid=1 for exactly one cycle with core_char=index; next state WAIT.
- REQ-007 WAIT: on core_valid_out register m_data = core_char_out+0x41, go EMIT; if core_valid_out absent, stay in WAIT (no timeout).
- REQ-008 EMIT: m_valid held with m_data stable until m_ready; on handshake -> IDLE; char_cnt increments on handshake of letters only, saturating at 0xFFFF.
- REQ-009 Letter latency: accept in cycle N, core_valid N+1, capture N+2, m_valid from N+3; throughput one byte per 4 cycles with m_ready held high.
- REQ-010 core_valid and core_load SHALL never be high in the same cycle; cfg_valid arriving outside IDLE is held off until IDLE (no load mid-character).
- REQ-011 Output is always uppercase regardless of input case.

Reset
- REQ-012 rst low at a clock edge SHALL force IDLE, s_ready=0 that cycle, m_valid=0, m_data=0, core_valid=0, core_load=0, core_char=0, core_pos*=0, cfg_err=0, char_cnt=0; reset mid-character discards the character.
- REQ-013 The core is reset by its own reset; enigma_seq does not issue core_load on reset exit.

Configuration
- REQ-014 Macro ENIGMA_PASSTHRU_EN defined: non-letter bytes go IDLE->EMIT unchanged, no core step. Undefined: non-letter bytes accepted and dropped (IDLE->IDLE), no m_valid.

Structure
- REQ-015 Shared package enigma_pkg holds the FSM state enum, ASCII_A (0x41), ASCII_LOWER_A (0x61), NUM_LETTERS (26), and a letter-index typedef (5 bits).
- REQ-016 One sub-module ascii_letter_map: combinational byte -> {is_letter, index}; the FSM stays in enigma_seq.

Verification
- REQ-017 Reset, cfg 0/0/0, send 'A' -> m_data 'U' at N+3, char_cnt 1.
- REQ-018 Reset, cfg 0/0/0, send 'u' -> m_data 'A', proving case folding and reciprocity.
- REQ-019 cfg 30/2/25 -> core_pos 0/2/25, cfg_err one pulse, char_cnt 0.
- REQ-020 Send ' ' (0x20): with ENIGMA_PASSTHRU_EN m_data 0x20, core_valid never high; without it no m_valid.
- REQ-021 m_ready low 10 cycles in EMIT -> m_data stable, s_ready 0, no core_valid; cfg_valid raised during WAIT -> core_load only after EMIT handshake.
- REQ-022 rst low during WAIT -> next cycle IDLE, m_valid 0, char_cnt 0, late core_valid_out ignored.
